fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Instruction-memory and decode-side handshake bundle for fetch_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction fetch with redirect/trap flushing.
//            Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00008000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  input  wire logic        trap_valid,
  input  wire logic [31:0] trap_pc,
  fetch_ctrl_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_flushed
`endif
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pending_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        w_redir;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;

  // Trap beats branch when both resolve in the same cycle.
  assign w_redir      = trap_valid | redirect_valid;
  assign w_target_raw = trap_valid ? trap_pc : redirect_pc;
  assign w_target     = w_target_raw & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_REQ: begin
        if (w_redir)           w_state_nxt = bus.imem_ack ? ST_REQ : ST_FLUSH;
        else if (bus.imem_ack) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_redir || bus.inst_ready) w_state_nxt = ST_REQ;
      end
      ST_FLUSH: begin
        if (bus.imem_ack) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.imem_addr  = r_fetch_pc;
    bus.inst_valid = 1'b0;
    case (r_state)
      ST_REQ, ST_FLUSH: bus.imem_req   = ~rst;
      ST_HOLD:          bus.inst_valid = 1'b1;
      default:          bus.imem_req   = 1'b0;
    endcase
  end

  assign bus.inst          = r_inst;
  assign bus.inst_pc       = r_inst_pc;
  assign bus.inst_pc_plus4 = r_inst_pc + 32'd4;

  // fetch_pc never moves while a request is outstanding, keeping imem_addr stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= 32'd0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_redir) begin
            if (bus.imem_ack) r_fetch_pc   <= w_target;
            else              r_pending_pc <= w_target;
          end else if (bus.imem_ack) begin
            r_inst     <= bus.imem_rdata;
            r_inst_pc  <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        ST_HOLD: begin
          if (w_redir) r_fetch_pc <= w_target;
        end
        ST_FLUSH: begin
          if (w_redir) begin
            if (bus.imem_ack) r_fetch_pc   <= w_target;
            else              r_pending_pc <= w_target;
          end else if (bus.imem_ack) begin
            r_fetch_pc <= r_pending_pc;
          end
        end
        default: r_fetch_pc <= r_fetch_pc;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic w_xfer;
  logic w_drop;

  // A HOLD word hit by a redirect counts as dropped, not delivered.
  assign w_xfer = (r_state == ST_HOLD) && bus.inst_ready && !w_redir;
  assign w_drop = ((r_state == ST_REQ)   && w_redir && bus.imem_ack) ||
                  ((r_state == ST_FLUSH) && bus.imem_ack) ||
                  ((r_state == ST_HOLD)  && w_redir);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
    end else begin
      if (w_xfer) perf_fetched <= perf_fetched + 32'd1;
      if (w_drop) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Self-checking bench for fetch_ctrl (directed scenarios + random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h00008000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  int          errors = 0;
  int          checks = 0;

  fetch_ctrl_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .bus            (bus.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    trap_valid     = 1'b0;
    trap_pc        = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.inst_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: inst_valid timeout, got %b want 1", tag, bus.inst_valid);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    trap_valid     = 1'b0;
    trap_pc        = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    tick();
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h want 0", bus.inst); end
    checks++; if (bus.inst_pc !== 32'd0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin errors++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_flushed); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL release_req: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RESET_PC); end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL first_edge_req: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc = RESET_PC;
    do_reset();
    bus.imem_ack   = 1'b1;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid("seq");
      checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.inst_pc, exp_pc); end
      checks++; if (bus.inst_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_plus4[%0d]: got %h want %h", i, bus.inst_pc_plus4, exp_pc + 32'd4); end
      checks++; if (bus.inst !== mem_word(exp_pc)) begin errors++; $display("FAIL seq_inst[%0d]: got %h want %h", i, bus.inst, mem_word(exp_pc)); end
      exp_pc += 32'd4;
      tick();
    end
  endtask

  task automatic test_hold_stall();
    do_reset();
    bus.imem_ack   = 1'b1;
    bus.inst_ready = 1'b1;
    wait_valid("stall_first");
    tick();
    bus.inst_ready = 1'b0;
    wait_valid("stall_second");
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.inst_pc !== 32'h8004 || bus.inst !== mem_word(32'h8004) ||
          bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got pc=%h inst=%h req=%b valid=%b want pc=8004 inst=%h req=0 valid=1",
                 i, bus.inst_pc, bus.inst, bus.imem_req, bus.inst_valid, mem_word(32'h8004));
      end
    end
    bus.inst_ready = 1'b1;
    tick();
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8008) begin errors++; $display("FAIL stall_release: got valid=%b req=%b addr=%h want 0/1/8008", bus.inst_valid, bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_flush();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h9000;
    tick();
    redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL flush_enter: got req=%b addr=%h valid=%b want 1/%h/0", bus.imem_req, bus.imem_addr, bus.inst_valid, RESET_PC); end
    tick();
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL flush_wait: got valid=%b addr=%h want 0/%h", bus.inst_valid, bus.imem_addr, RESET_PC); end
    bus.imem_ack = 1'b1;
    tick();
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h9000) begin errors++; $display("FAIL flush_exit: got valid=%b req=%b addr=%h want 0/1/9000", bus.inst_valid, bus.imem_req, bus.imem_addr); end
    bus.inst_ready = 1'b1;
    wait_valid("flush_next");
    checks++; if (bus.inst_pc !== 32'h9000) begin errors++; $display("FAIL flush_next_pc: got %h want 9000", bus.inst_pc); end
  endtask

  task automatic test_priority();
    do_reset();
    trap_valid     = 1'b1;
    trap_pc        = 32'h100;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h9000;
    tick();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    bus.imem_ack   = 1'b1;
    tick();
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL prio_flush_addr: got %h want 100", bus.imem_addr); end
    do_reset();
    bus.imem_ack   = 1'b1;
    trap_valid     = 1'b1;
    trap_pc        = 32'h103;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h9000;
    tick();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL prio_ack_addr: got addr=%h valid=%b want 100/0", bus.imem_addr, bus.inst_valid); end
    bus.inst_ready = 1'b1;
    wait_valid("prio_next");
    checks++; if (bus.inst_pc !== 32'h100) begin errors++; $display("FAIL prio_next_pc: got %h want 100", bus.inst_pc); end
  endtask

  task automatic test_double_redirect();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] f0;
`endif
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hA000;
    tick();
    redirect_pc = 32'hB000;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    f0 = perf_flushed;
`endif
    bus.imem_ack = 1'b1;
    tick();
    checks++; if (bus.imem_addr !== 32'hB000 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL double_addr: got addr=%h valid=%b want B000/0", bus.imem_addr, bus.inst_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_flushed !== f0 + 32'd1) begin errors++; $display("FAIL double_perf_flushed: got %h want %h", perf_flushed, f0 + 32'd1); end
`endif
    bus.inst_ready = 1'b1;
    wait_valid("double_next");
    checks++; if (bus.inst_pc !== 32'hB000) begin errors++; $display("FAIL double_next_pc: got %h want B000", bus.inst_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.imem_ack   = 1'b1;
    bus.inst_ready = 1'b1;
    wait_valid("async_first");
    tick();
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hC000;
    tick();
    redirect_valid = 1'b0;
    checks++; if (bus.inst_pc !== RESET_PC || bus.imem_addr !== 32'h8004) begin errors++; $display("FAIL async_pre: got pc=%h addr=%h want %h/8004", bus.inst_pc, bus.imem_addr, RESET_PC); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'd0 ||
        bus.inst !== 32'd0 || bus.imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL async_reset: got req=%b valid=%b pc=%h inst=%h addr=%h want 0/0/0/0/%h",
               bus.imem_req, bus.inst_valid, bus.inst_pc, bus.inst, bus.imem_addr, RESET_PC);
    end
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC || bus.inst !== mem_word(RESET_PC)) begin errors++; $display("FAIL async_first_ack: got valid=%b pc=%h inst=%h want 1/%h/%h", bus.inst_valid, bus.inst_pc, bus.inst, RESET_PC, mem_word(RESET_PC)); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc = 32'hFFFF_FFF8;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFB;
    tick();
    redirect_valid = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid("wrap");
      checks++; if (bus.inst_pc !== exp_pc) begin errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, bus.inst_pc, exp_pc); end
      checks++; if (bus.inst_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL wrap_plus4[%0d]: got %h want %h", i, bus.inst_pc_plus4, exp_pc + 32'd4); end
      exp_pc += 32'd4;
      tick();
    end
  endtask

  // Reference: delivered PCs form +4 runs, each restarted at the aligned target of the latest redirect.
  task automatic test_random();
    logic [31:0] exp_pc    = RESET_PC;
    logic        prev_out  = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          xfers     = 0;
    logic        redir;
    logic [31:0] tgt;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bus.inst_valid && bus.imem_req) begin
        checks++; errors++;
        $display("FAIL rand_exclusive[%0d]: got req=1 valid=1 want not both", cyc);
      end
      if (prev_out) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL rand_addr_stable[%0d]: got req=%b addr=%h want 1/%h", cyc, bus.imem_req, bus.imem_addr, prev_addr);
        end
      end
      bus.imem_ack   = ($urandom_range(0, 9) < 6);
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 8);
      trap_valid     = ($urandom_range(0, 99) < 4);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      trap_pc        = $urandom;
      redir = redirect_valid || trap_valid;
      tgt   = (trap_valid ? trap_pc : redirect_pc) & 32'hFFFF_FFFC;
      if (redir) begin
        exp_pc = tgt;
      end else if (bus.inst_valid && bus.inst_ready) begin
        checks++;
        if (bus.inst_pc !== exp_pc || bus.inst !== mem_word(exp_pc) || bus.inst_pc_plus4 !== exp_pc + 32'd4) begin
          errors++;
          $display("FAIL rand_xfer[%0d]: got pc=%h inst=%h plus4=%h want %h/%h/%h",
                   cyc, bus.inst_pc, bus.inst, bus.inst_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc += 32'd4;
        xfers++;
      end
      prev_out  = bus.imem_req && !bus.imem_ack;
      prev_addr = bus.imem_addr;
      tick();
    end
    redirect_valid = 1'b0;
    trap_valid     = 1'b0;
    checks++; if (xfers < 100) begin errors++; $display("FAIL rand_activity: got %0d transfers want >= 100", xfers); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'(xfers)) begin errors++; $display("FAIL rand_perf_fetched: got %0d want %0d", perf_fetched, xfers); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_flush();
    test_priority();
    test_double_redirect();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
